// File: rtl/random_pkg.sv
// Shared types and helpers for the Galois LFSR bank.
// Holds the tap table, the WARM/RUN state enum and the reset-seed rotation.
package random_pkg;

    typedef enum logic {
        WARM,
        RUN
    } lfsr_state_t;

    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            24:      return 32'h00E1_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0;
        endcase
    endfunction

    // rotl(base, n) within width bits, forced odd so no lane starts at zero
    function automatic logic [31:0] seed_rotl(
        input logic [31:0] base,
        input int          width,
        input int          n
    );
        logic [31:0] mask;
        logic [31:0] r;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        r    = base & mask;
        for (int k = 0; k < (n % width); k++) begin
            r = ((r << 1) | (r >> (width - 1))) & mask;
        end
        return r | 32'd1;
    endfunction

endpackage

// File: rtl/random_lfsr_bank_if.sv
// Seed-load and sample-stream handshakes of the LFSR bank.
// The bank sits on the master side; consumers and seeders use slave.
interface random_lfsr_bank_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                      seed_valid;
    logic                      seed_ready;
    logic [CW-1:0]             seed_chan;
    logic [WIDTH-1:0]          seed_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS*WIDTH-1:0] out_data;

    modport master (
        input  seed_valid, seed_chan, seed_data, out_ready,
        output seed_ready, out_valid, out_data
    );

    modport slave (
        output seed_valid, seed_chan, seed_data, out_ready,
        input  seed_ready, out_valid, out_data
    );

endinterface

// File: rtl/random_lfsr_lane.sv
// One Galois LFSR lane: load has priority over step.
// Taps come from the shared table for the lane width.
module random_lfsr_lane
    import random_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RST_SEED = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] state
);
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RST_SEED;
        end else if (load) begin
            state <= load_data;
        end else if (step) begin
            state <= (state >> 1) ^ (state[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/random_lfsr_bank.sv
// Bank of independent Galois LFSR lanes with warm-up and valid/ready output.
// Define RANDOM_LFSR_ZERO_GUARD_EN to replace zero seeds by the lane reset seed.
module random_lfsr_bank
    import random_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               CHANNELS  = 4,
    parameter int               WARMUP    = 16,
    parameter logic [WIDTH-1:0] SEED_BASE = WIDTH'('hACE1)
) (
    input logic                clock,
    input logic                reset,
    random_lfsr_bank_if.master bus
);
    localparam int          CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [7:0]  WU  = 8'(WARMUP);
    localparam logic [CW:0] NCH = (CW + 1)'(CHANNELS);

    if (WIDTH != 8 && WIDTH != 16 && WIDTH != 24 && WIDTH != 32) begin : g_bad_width
        $error("random_lfsr_bank: WIDTH must be 8, 16, 24 or 32");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_chan
        $error("random_lfsr_bank: CHANNELS must be 1..16");
    end
    if (WARMUP < 0 || WARMUP > 255) begin : g_bad_warm
        $error("random_lfsr_bank: WARMUP must be 0..255");
    end

    lfsr_state_t state_q;
    logic [7:0]  warm_q;
    logic        run_q;
    logic        out_fire;
    logic        seed_hit;
    logic        step_all;

    assign bus.out_valid  = run_q;
    assign bus.seed_ready = run_q;

    assign out_fire = bus.out_ready && run_q;
    // out-of-range lanes complete the handshake but touch nothing
    assign seed_hit = bus.seed_valid && run_q && ({1'b0, bus.seed_chan} < NCH);
    assign step_all = (state_q == WARM) || out_fire;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        localparam logic [WIDTH-1:0] RST = WIDTH'(seed_rotl(32'(SEED_BASE), WIDTH, i));

        logic             ld;
        logic [WIDTH-1:0] ld_data;
        logic [WIDTH-1:0] lane_q;

        assign ld = seed_hit && (bus.seed_chan == CW'(i));
`ifdef RANDOM_LFSR_ZERO_GUARD_EN
        assign ld_data = (bus.seed_data == '0) ? RST : bus.seed_data;
`else
        assign ld_data = bus.seed_data;
`endif

        random_lfsr_lane #(
            .WIDTH   (WIDTH),
            .RST_SEED(RST)
        ) u_lane (
            .clock    (clock),
            .reset    (reset),
            .step     (step_all),
            .load     (ld),
            .load_data(ld_data),
            .state    (lane_q)
        );

        assign bus.out_data[i*WIDTH +: WIDTH] = lane_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= (WARMUP == 0) ? RUN : WARM;
            warm_q  <= WU;
            run_q   <= (WARMUP == 0);
        end else begin
            unique case (state_q)
                WARM: begin
                    warm_q <= warm_q - 8'd1;
                    if (warm_q <= 8'd1) begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (seed_hit && WARMUP != 0) begin
                        state_q <= WARM;
                        warm_q  <= WU;
                        run_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
